// File: rtl/dapuf_pkg.sv
// Shared types and constants for the double-arbiter PUF evaluation controller.
package dapuf_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDisch,
    StFire,
    StSample,
    StNext,
    StOut
  } state_e;

  localparam logic [63:0] LFSR_MASK = 64'hD800_0000_0000_0000;

  localparam int unsigned DEF_CHAL_W     = 64;
  localparam int unsigned DEF_SETTLE_CYC = 16;
  localparam int unsigned DEF_REPEAT     = 7;
  localparam int unsigned DEF_RESP_BITS  = 32;

endpackage

// File: rtl/puf_lfsr64.sv
// 64-bit Galois right-shift LFSR that sources PUF challenges.
module puf_lfsr64
  import dapuf_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [63:0] seed,
  input  logic        step,
  output logic [63:0] state
);

  logic [63:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      // An all-zero state would lock up the LFSR.
      state_d = (seed == '0) ? 64'h1 : seed;
    end else if (step) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? LFSR_MASK : 64'h0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/dapuf_eval_ctrl.sv
// Drives challenges and excitation edges into the DAPUF, majority-votes the repeated
// responses and packs the voted bits into a word offered on a valid/ready port.
module dapuf_eval_ctrl
  import dapuf_pkg::*;
#(
  parameter int unsigned CHAL_W     = DEF_CHAL_W,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned REPEAT     = DEF_REPEAT,
  parameter int unsigned RESP_BITS  = DEF_RESP_BITS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [CHAL_W-1:0]                seed,
  output logic                             busy,
  output logic [CHAL_W-1:0]                chal_o,
  output logic                             excite_o,
  input  logic                             puf_resp_i,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [RESP_BITS-1:0]             resp_data,
  output logic [$clog2(RESP_BITS+1)-1:0]   unstable_cnt
);

  localparam int unsigned SetW = $clog2(SETTLE_CYC);
  localparam int unsigned CntW = $clog2(REPEAT + 1);
  localparam int unsigned IdxW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int unsigned UnsW = $clog2(RESP_BITS + 1);

  localparam logic [SetW-1:0] SetLast = SetW'(SETTLE_CYC - 1);
  localparam logic [CntW-1:0] RepAll  = CntW'(REPEAT);
  localparam logic [CntW-1:0] RepHalf = CntW'(REPEAT / 2);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(RESP_BITS - 1);

  state_e state_q, state_d;

  logic [SetW-1:0]      set_q, set_d;
  logic [CntW-1:0]      eval_q, eval_d;
  logic [CntW-1:0]      ones_q, ones_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [RESP_BITS-1:0] data_q, data_d;
  logic [UnsW-1:0]      uns_q, uns_d;
  logic                 busy_q, busy_d;
  logic                 excite_q, excite_d;
  logic                 valid_q, valid_d;
  logic [1:0]           sync_q;

  logic        lfsr_load;
  logic        lfsr_step;
  logic [63:0] lfsr_state;
  logic        vote;
  logic        unstable;

  puf_lfsr64 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (seed),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  assign vote     = (ones_q > RepHalf);
  assign unstable = (ones_q != '0) && (ones_q != RepAll);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StDisch;
      StDisch:  if (set_q == SetLast) state_d = StFire;
      StFire:   if (set_q == SetLast) state_d = StSample;
      StSample: state_d = (eval_q + CntW'(1) == RepAll) ? StNext : StDisch;
      StNext:   state_d = (idx_q == IdxLast) ? StOut : StDisch;
      StOut:    if (resp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next-state and registered-output decode
  always_comb begin
    set_d     = set_q;
    eval_d    = eval_q;
    ones_d    = ones_q;
    idx_d     = idx_q;
    data_d    = data_q;
    uns_d     = uns_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          lfsr_load = 1'b1;
          set_d     = '0;
          eval_d    = '0;
          ones_d    = '0;
          idx_d     = '0;
          data_d    = '0;
          uns_d     = '0;
        end
      end
      StDisch, StFire: begin
        set_d = (set_q == SetLast) ? '0 : set_q + SetW'(1);
      end
      StSample: begin
        ones_d = ones_q + CntW'(sync_q[1]);
        eval_d = eval_q + CntW'(1);
      end
      StNext: begin
        data_d[idx_q] = vote;
        if (unstable) uns_d = uns_q + UnsW'(1);
        lfsr_step = 1'b1;
        ones_d    = '0;
        eval_d    = '0;
        idx_d     = idx_q + IdxW'(1);
      end
      default: ;
    endcase

    // Outputs are decoded from the next state so they line up with the state register.
    busy_d   = (state_d != StIdle);
    excite_d = (state_d == StFire);
    valid_d  = (state_d == StOut);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_q    <= '0;
      eval_q   <= '0;
      ones_q   <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      uns_q    <= '0;
      busy_q   <= 1'b0;
      excite_q <= 1'b0;
      valid_q  <= 1'b0;
      sync_q   <= '0;
    end else begin
      set_q    <= set_d;
      eval_q   <= eval_d;
      ones_q   <= ones_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      uns_q    <= uns_d;
      busy_q   <= busy_d;
      excite_q <= excite_d;
      valid_q  <= valid_d;
      sync_q   <= {sync_q[0], puf_resp_i};
    end
  end

  assign busy         = busy_q;
  assign chal_o       = lfsr_state;
  assign excite_o     = excite_q;
  assign resp_valid   = valid_q;
  assign resp_data    = data_q;
  assign unstable_cnt = uns_q;

endmodule

// File: tb/tb_dapuf_eval_ctrl.sv
// Scoreboard bench for dapuf_eval_ctrl with a behavioural PUF and reference model.
module tb_dapuf_eval_ctrl;

  localparam int unsigned SC       = 4;
  localparam int unsigned RP       = 3;
  localparam int unsigned RB       = 4;
  localparam int unsigned UW       = $clog2(RB + 1);
  localparam int unsigned CHAL_PER = RP * (2 * SC + 1) + 1;
  localparam int unsigned LAT      = RB * CHAL_PER + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [63:0]   seed = '0;
  logic          puf_resp_i = 1'b0;
  logic          resp_ready = 1'b0;
  logic          busy, excite_o, resp_valid;
  logic [63:0]   chal_o;
  logic [RB-1:0] resp_data;
  logic [UW-1:0] unstable_cnt;

  dapuf_eval_ctrl #(
    .CHAL_W     (64),
    .SETTLE_CYC (SC),
    .REPEAT     (RP),
    .RESP_BITS  (RB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .seed         (seed),
    .busy         (busy),
    .chal_o       (chal_o),
    .excite_o     (excite_o),
    .puf_resp_i   (puf_resp_i),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .unstable_cnt (unstable_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural PUF: 0 = constant, 1 = per-evaluation pattern, 2 = challenge-keyed with noise
  int          mode = 0;
  logic        cval = 1'b1;
  logic [2:0]  pat = '0;
  logic [63:0] key = '0;

  function automatic logic puf_fn(input logic [63:0] c, input int e);
    logic b;
    case (mode)
      0: b = cval;
      1: b = pat[e];
      default: begin
        b = ^(c & key);
        if (c[9:8] == 2'b00 && e == 1) b = ~b;
      end
    endcase
    return b;
  endfunction

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'h0);
  endfunction

  logic [63:0] seq [0:RB];

  task automatic model(input logic [63:0] sd, output logic [RB-1:0] w, output logic [UW-1:0] u);
    logic [63:0] s;
    int ones, un;
    s  = (sd == 64'h0) ? 64'h1 : sd;
    w  = '0;
    un = 0;
    for (int k = 0; k < RB; k++) begin
      seq[k] = s;
      ones = 0;
      for (int e = 0; e < RP; e++) ones += int'(puf_fn(s, e));
      w[k] = (2 * ones > RP);
      if (ones > 0 && ones < int'(RP)) un++;
      s = lfsr_next(s);
    end
    seq[RB] = s;
    u = UW'(un);
  endtask

  // PUF driver: a new response per excitation rising edge, indexed within the challenge
  logic [63:0] last_chal = '0;
  logic        last_exc = 1'b0;
  int          ev = 0;
  always @(posedge clk) begin
    #1;
    if (chal_o !== last_chal) begin
      last_chal = chal_o;
      ev = 0;
    end
    if (excite_o && !last_exc) begin
      puf_resp_i = puf_fn(chal_o, ev);
      ev++;
    end
    last_exc = excite_o;
  end

  logic [RB-1:0] q_data [$];
  logic [UW-1:0] q_uns  [$];

  // Scoreboard monitor
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n && resp_valid && resp_ready) begin
      if (q_data.size() == 0) begin
        chk("sb_queue_nonempty", 64'(q_data.size()), 64'd1);
      end else begin
        chk("sb_resp_data", 64'(resp_data), 64'(q_data.pop_front()));
        chk("sb_unstable_cnt", 64'(unstable_cnt), 64'(q_uns.pop_front()));
      end
    end
  end

  // Every excitation pulse must be exactly SC cycles wide
  int hi_len = 0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) hi_len = 0;
    else if (excite_o) hi_len++;
    else if (hi_len != 0) begin
      chk("excite_pulse_len", 64'(hi_len), 64'(SC));
      hi_len = 0;
    end
  end

  task automatic run_word(input logic [63:0] sd, input int delay, input bit glitch,
                          input bit rst_mid);
    logic [RB-1:0] w;
    logic [UW-1:0] u;
    int s, o, idx;
    bit seen, aborted;
    model(sd, w, u);
    if (!rst_mid) begin
      q_data.push_back(w);
      q_uns.push_back(u);
    end
    resp_ready = (delay == 0);
    @(negedge clk);
    start = 1'b1;
    seed  = sd;
    s     = cyc;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    aborted = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      o = cyc - s;
      if (resp_valid) begin
        seen = 1'b1;
      end else begin
        idx = (o - 1) / int'(CHAL_PER);
        if (idx <= int'(RB)) chk("chal_seq", chal_o, seq[idx]);
        chk("busy_run", 64'(busy), 64'd1);
        if (o == 1) begin
          chk("clear_data", 64'(resp_data), 64'd0);
          chk("clear_unstable", 64'(unstable_cnt), 64'd0);
        end
        if (glitch && o == 3) begin
          start = 1'b1;
          seed  = ~sd;
        end
        if (glitch && o == 4) begin
          start = 1'b0;
          seed  = sd;
        end
        if (rst_mid && o > 30 && excite_o) begin
          #1 rst_n = 1'b0;
          #1;
          chk("rst_excite", 64'(excite_o), 64'd0);
          chk("rst_busy", 64'(busy), 64'd0);
          chk("rst_valid", 64'(resp_valid), 64'd0);
          chk("rst_chal", chal_o, 64'd0);
          chk("rst_data", 64'(resp_data), 64'd0);
          @(negedge clk);
          #3 rst_n = 1'b1;
          @(negedge clk);
          chk("post_rst_idle", 64'(busy), 64'd0);
          aborted = 1'b1;
          seen = 1'b1;
        end
        if (!seen) @(negedge clk);
      end
    end
    start = 1'b0;
    if (aborted) return;
    if (!resp_valid) begin
      chk("resp_valid_timeout", 64'(resp_valid), 64'd1);
      return;
    end
    chk("latency", 64'(o), 64'(LAT));
    for (int d = 0; d < delay; d++) begin
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_data", 64'(resp_data), 64'(w));
      chk("hold_unstable", 64'(unstable_cnt), 64'(u));
      chk("hold_chal", chal_o, seq[RB]);
      chk("hold_excite", 64'(excite_o), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    chk("valid_at_ready", 64'(resp_valid), 64'd1);
    @(negedge clk);
    chk("busy_after_hs", 64'(busy), 64'd0);
    chk("valid_after_hs", 64'(resp_valid), 64'd0);
    resp_ready = 1'b0;
    chk("data_kept", 64'(resp_data), 64'(w));
    chk("unstable_kept", 64'(unstable_cnt), 64'(u));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_excite", 64'(excite_o), 64'd0);
    chk("reset_chal", chal_o, 64'd0);
    chk("reset_valid", 64'(resp_valid), 64'd0);
    chk("reset_data", 64'(resp_data), 64'd0);
    chk("reset_unstable", 64'(unstable_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    mode = 0; cval = 1'b1;
    run_word(64'h1, 0, 1'b0, 1'b0);
    cval = 1'b0;
    run_word(64'h0, 0, 1'b0, 1'b0);
    mode = 1; pat = 3'b101;
    run_word({$urandom, $urandom}, 0, 1'b0, 1'b0);
    pat = 3'b010;
    run_word({$urandom, $urandom}, 0, 1'b0, 1'b0);
    mode = 0; cval = 1'b1;
    run_word({$urandom, $urandom}, 10, 1'b0, 1'b0);
    mode = 2; key = {$urandom, $urandom};
    run_word({$urandom, $urandom}, 0, 1'b0, 1'b1);
    run_word({$urandom, $urandom}, 0, 1'b0, 1'b0);
    run_word({$urandom, $urandom}, 2, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      key = {$urandom, $urandom};
      run_word({$urandom, $urandom}, int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end
    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(q_data.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dapuf_eval_ctrl.md
# dapuf_eval_ctrl

Challenge-driving and response-collecting controller for the double-arbiter PUF array: it is the initiator that feeds the PUF its 64-bit challenges and excitation edges, then reads back the single-bit response. Challenges are generated from a seeded 64-bit LFSR. Each challenge is evaluated REPEAT times and reduced by majority vote. RESP_BITS voted bits are packed into one response word and offered on a valid/ready output port, with a count of unstable challenges.

## Interface
- CHAL_W, 64: challenge width; fixed at 64 to match the PUF.
- SETTLE_CYC, 16: cycles per excitation phase (low, then high); must be ≥3.
- REPEAT, 7: evaluations per challenge; must be odd and ≥1.
- RESP_BITS, 32: voted bits per response word.
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request; honoured only in IDLE.
- seed  in  64  LFSR seed, sampled on an accepted start.
- busy  out  1  high from the cycle after an accepted start until the response handshake completes.
- chal_o  out  64  challenge to the PUF; stable for all REPEAT evaluations of a challenge.
- excite_o  out  1  drives both exciteL and exciteR of the PUF.
- puf_resp_i  in  1  PUF response; asynchronous to clk and synchronised internally.
- resp_valid  out  1  response word available.
- resp_ready  in  1  consumer accepts the word.
- resp_data  out  RESP_BITS  voted bits; challenge k goes to bit k.
- unstable_cnt  out  $clog2(RESP_BITS+1)  number of challenges whose evaluations disagreed.

## Operation
- States: IDLE, DISCH, FIRE, SAMPLE, NEXT, OUT.
- IDLE:
  - start=1 loads the LFSR with seed. A seed of 0 is replaced by 64'h1.
  - Clears the ones, eval, bit, unstable and word counters.
  - Goes to DISCH.
- DISCH: excite_o=0 for SETTLE_CYC cycles, which resets the arbiters. Then goes to FIRE.
- FIRE: excite_o=1 for SETTLE_CYC cycles. Then goes to SAMPLE.
- SAMPLE (1 cycle):
  - excite_o=0.
  - ones += output of the 2-flop synchroniser on puf_resp_i.
  - eval += 1.
  - If eval < REPEAT, go to DISCH; otherwise go to NEXT.
- NEXT (1 cycle):
  - bit = (ones > REPEAT/2), written into resp_data[bit_idx].
  - unstable_cnt += 1 if 0 < ones < REPEAT.
  - Step the LFSR and clear ones and eval.
  - bit_idx == RESP_BITS-1 goes to OUT; otherwise go to DISCH.
- OUT:
  - resp_valid=1.
  - On resp_valid && resp_ready, go to IDLE and deassert busy the following cycle.
- LFSR step is Galois right-shift: lfsr = (lfsr>>1) ^ (lfsr[0] ? 64'hD800_0000_0000_0000 : 0).
- chal_o = LFSR state.
- start while not IDLE is ignored.
- resp_ready outside OUT has no effect.

## Timing
- Reset values: busy=0, excite_o=0, chal_o=0, resp_valid=0, resp_data=0, unstable_cnt=0, state=IDLE.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). Operation does not resume.
- start accepted at edge t: busy=1 and chal_o=seed from t+1, and the first DISCH cycle is t+1.
- Per evaluation: 2·SETTLE_CYC+1 cycles. Per challenge: REPEAT·(2·SETTLE_CYC+1)+1 cycles.
- All outputs are registered. excite_o has no glitches, with exactly SETTLE_CYC consecutive high cycles per evaluation.
- Back-pressure in OUT:
  - resp_data, unstable_cnt and resp_valid are held.
  - chal_o is held.
  - excite_o stays 0.
- resp_data and unstable_cnt stay valid after the handshake until the next accepted start clears them.

## Structure
- Package dapuf_pkg holds:
  - the state enum;
  - LFSR_MASK = 64'hD800_0000_0000_0000;
  - default parameter constants.
- One sub-module, puf_lfsr64, with ports clk, rst_n, load, seed, step, and state output.
- The synchroniser and voting logic are inline.

## Test plan
1. Parameters SETTLE_CYC=4, REPEAT=3, RESP_BITS=4; seed=1; puf_resp_i tied 1.
   - chal_o shows 64'h1, then 64'hD800_0000_0000_0000.
   - resp_data=4'hF, unstable_cnt=0.
   - resp_valid rises exactly 4·(3·9+1)+1 cycles after start.
2. seed=0 → first chal_o=64'h1. puf_resp_i tied 0 → resp_data=0, unstable_cnt=0.
3. PUF model returns 1,0,1 across the three evaluations of every challenge → resp_data=4'hF, unstable_cnt=4. Model returns 0,1,0 → resp_data=0, unstable_cnt=4.
4. resp_ready held low 10 cycles after resp_valid → resp_data, chal_o and resp_valid are held, excite_o=0. Then resp_ready=1 → busy=0 one cycle later.
5. rst_n pulsed low during FIRE → excite_o, busy and resp_valid are 0 asynchronously. A start after release yields a full correct run.
6. start pulsed during DISCH → ignored: the run completes with the unchanged seed sequence and each excite_o high pulse is exactly 4 cycles.
